// File: rtl/callret_ctrl.sv
// Call/return controller that drives push/pop strobes toward a LIFO return-address stack.
// It tracks stack depth, redirects the PC on return, and handles interrupt entry and exit.
module callret_ctrl #(
    parameter int            AW      = 10,
    parameter int            DEPTH   = 8,
    parameter logic [AW-1:0] IRQ_VEC = 10'h3F0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       reti,
    input  logic                       ei,
    input  logic                       di,
    input  logic                       irq,
    input  logic [AW-1:0]              pc_cur,
    input  logic [AW-1:0]              pc_next,
    input  logic [AW-1:0]              pop_data,
    output logic                       push,
    output logic [AW-1:0]              push_data,
    output logic                       pop,
    output logic                       stall,
    output logic                       squash,
    output logic                       redirect,
    output logic [AW-1:0]              redirect_pc,
    output logic                       ie,
    output logic                       in_isr,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int DW = $clog2(DEPTH+1);
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_C   = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_RDIR = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   depth_r, depth_s;
    logic            push_r, push_s;
    logic [AW-1:0]   push_data_r, push_data_s;
    logic            pop_r, pop_s;
    logic            redirect_r, redirect_s;
    logic [AW-1:0]   redirect_pc_r, redirect_pc_s;
    logic            ie_r, ie_s;
    logic            in_isr_r, in_isr_s;
    logic            ovf_r, ovf_s;
    logic            unf_r, unf_s;
    logic            reti_r, reti_s;
    logic            stall_s, squash_s;
    logic            full_s, empty_s;

    // Next-state decode: accept priority is irq, then ret/reti, then call
    always_comb begin
        state_s       = state_r;
        depth_s       = depth_r;
        push_s        = 1'b0;
        push_data_s   = push_data_r;
        pop_s         = 1'b0;
        redirect_s    = 1'b0;
        redirect_pc_s = redirect_pc_r;
        ie_s          = ie_r;
        in_isr_s      = in_isr_r;
        ovf_s         = ovf_r;
        unf_s         = unf_r;
        reti_s        = reti_r;
        stall_s       = 1'b0;
        squash_s      = 1'b0;
        full_s        = (depth_r == DEPTH_C);
        empty_s       = (depth_r == {DW{1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (irq && ie_r && !full_s) begin
                    squash_s      = 1'b1;
                    push_s        = 1'b1;
                    push_data_s   = pc_cur;
                    redirect_s    = 1'b1;
                    redirect_pc_s = IRQ_VEC;
                    depth_s       = depth_r + ONE_C;
                    ie_s          = 1'b0;
                    in_isr_s      = 1'b1;
                end else begin
                    if (di) begin
                        ie_s = 1'b0;
                    end else if (ei) begin
                        ie_s = 1'b1;
                    end else begin
                        ie_s = ie_r;
                    end
                    // A return always shadows a simultaneous call, even when it underflows
                    if (ret || reti) begin
                        if (!empty_s) begin
                            stall_s = 1'b1;
                            pop_s   = 1'b1;
                            depth_s = depth_r - ONE_C;
                            reti_s  = reti;
                            state_s = ST_POP;
                        end else begin
                            unf_s = 1'b1;
                        end
                    end else if (call) begin
                        if (!full_s) begin
                            push_s      = 1'b1;
                            push_data_s = pc_next;
                            depth_s     = depth_r + ONE_C;
                        end else begin
                            ovf_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_POP: begin
                stall_s       = 1'b1;
                redirect_s    = 1'b1;
                redirect_pc_s = pop_data;
                state_s       = ST_RDIR;
            end
            ST_RDIR: begin
                if (reti_r) begin
                    ie_s     = 1'b1;
                    in_isr_s = 1'b0;
                end else begin
                    ie_s     = ie_r;
                    in_isr_s = in_isr_r;
                end
                reti_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered output update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            depth_r       <= {DW{1'b0}};
            push_r        <= 1'b0;
            push_data_r   <= {AW{1'b0}};
            pop_r         <= 1'b0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= {AW{1'b0}};
            ie_r          <= 1'b0;
            in_isr_r      <= 1'b0;
            ovf_r         <= 1'b0;
            unf_r         <= 1'b0;
            reti_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            depth_r       <= depth_s;
            push_r        <= push_s;
            push_data_r   <= push_data_s;
            pop_r         <= pop_s;
            redirect_r    <= redirect_s;
            redirect_pc_r <= redirect_pc_s;
            ie_r          <= ie_s;
            in_isr_r      <= in_isr_s;
            ovf_r         <= ovf_s;
            unf_r         <= unf_s;
            reti_r        <= reti_s;
        end
    end

    assign push        = push_r;
    assign push_data   = push_data_r;
    assign pop         = pop_r;
    assign stall       = stall_s;
    assign squash      = squash_s;
    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign ie          = ie_r;
    assign in_isr      = in_isr_r;
    assign depth       = depth_r;
    assign ovf_err     = ovf_r;
    assign unf_err     = unf_r;

endmodule

// File: tb/tb_callret_ctrl.sv
// Directed self-checking bench for callret_ctrl with hand-computed expectations.
module tb_callret_ctrl;

    logic        clk;
    logic        reset;
    logic        call, ret, reti, ei, di, irq;
    logic [9:0]  pc_cur, pc_next, pop_data;
    logic        push, pop, stall, squash, redirect, ie, in_isr, ovf_err, unf_err;
    logic [9:0]  push_data, redirect_pc;
    logic [3:0]  depth;

    int n_checks;
    int n_fail;
    int push_cnt;

    callret_ctrl #(.AW(10), .DEPTH(8), .IRQ_VEC(10'h3F0)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .reti(reti),
        .ei(ei), .di(di), .irq(irq), .pc_cur(pc_cur), .pc_next(pc_next),
        .pop_data(pop_data), .push(push), .push_data(push_data), .pop(pop),
        .stall(stall), .squash(squash), .redirect(redirect),
        .redirect_pc(redirect_pc), .ie(ie), .in_isr(in_isr), .depth(depth),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; push_cnt = 0;
        reset = 1'b0;
        call = 1'b0; ret = 1'b0; reti = 1'b0; ei = 1'b0; di = 1'b0; irq = 1'b0;
        pc_cur = 10'h000; pc_next = 10'h000; pop_data = 10'h000;
        step(); step();
        check_val("rst_depth", 32'(depth), 32'd0);
        check_val("rst_ie", 32'(ie), 32'd0);
        check_val("rst_in_isr", 32'(in_isr), 32'd0);
        check_val("rst_strobes", {29'd0, push, pop, redirect}, 32'd0);
        check_val("rst_push_data", 32'(push_data), 32'd0);
        check_val("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        check_val("rst_errs", {30'd0, ovf_err, unf_err}, 32'd0);
        reset = 1'b1;
        step();

        // call pushes pc_next
        call = 1'b1; pc_next = 10'h005; #1;
        check_val("call_stall_n", 32'(stall), 32'd0);
        step(); call = 1'b0; #1;
        check_val("call_push", 32'(push), 32'd1);
        check_val("call_push_data", 32'(push_data), 32'h005);
        check_val("call_depth", 32'(depth), 32'd1);
        check_val("call_stall_n1", 32'(stall), 32'd0);
        step();
        check_val("call_push_off", 32'(push), 32'd0);

        // ret with data on stack
        ret = 1'b1; #1;
        check_val("ret_stall_n", 32'(stall), 32'd1);
        check_val("ret_pop_n", 32'(pop), 32'd0);
        step(); ret = 1'b0; pop_data = 10'h005; #1;
        check_val("ret_pop_n1", 32'(pop), 32'd1);
        check_val("ret_stall_n1", 32'(stall), 32'd1);
        check_val("ret_depth", 32'(depth), 32'd0);
        step(); pop_data = 10'h000; #1;
        check_val("ret_redirect", 32'(redirect), 32'd1);
        check_val("ret_redirect_pc", 32'(redirect_pc), 32'h005);
        check_val("ret_stall_n2", 32'(stall), 32'd0);
        check_val("ret_pop_n2", 32'(pop), 32'd0);
        step();
        check_val("ret_redirect_off", 32'(redirect), 32'd0);

        // ret at empty stack
        ret = 1'b1; #1;
        check_val("unf_stall", 32'(stall), 32'd0);
        step(); ret = 1'b0; #1;
        check_val("unf_pop", 32'(pop), 32'd0);
        check_val("unf_err", 32'(unf_err), 32'd1);
        check_val("unf_depth", 32'(depth), 32'd0);

        // nine calls into an eight-deep stack
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; pc_next = 10'h100 + 10'(i);
            step();
            if (push) push_cnt++;
        end
        call = 1'b0;
        step();
        check_val("ovf_push_cnt", 32'(push_cnt), 32'd8);
        check_val("ovf_depth", 32'(depth), 32'd8);
        check_val("ovf_err", 32'(ovf_err), 32'd1);

        // enable interrupts; irq held while full is not accepted
        ei = 1'b1; step(); ei = 1'b0; #1;
        check_val("ei_set", 32'(ie), 32'd1);
        irq = 1'b1; pc_cur = 10'h020; #1;
        check_val("irq_full_squash", 32'(squash), 32'd0);
        step();
        check_val("irq_full_push", 32'(push), 32'd0);
        check_val("irq_full_redirect", 32'(redirect), 32'd0);

        // ret wins over the stalled irq, then irq is taken in the next IDLE cycle
        ret = 1'b1; #1;
        check_val("ret_full_stall", 32'(stall), 32'd1);
        step(); ret = 1'b0; pop_data = 10'h107; #1;
        check_val("ret_full_pop", 32'(pop), 32'd1);
        check_val("ret_full_depth", 32'(depth), 32'd7);
        check_val("pop_squash", 32'(squash), 32'd0);
        step(); pop_data = 10'h000; call = 1'b1; #1;
        check_val("rdir_pc", 32'(redirect_pc), 32'h107);
        check_val("rdir_squash", 32'(squash), 32'd0);
        step(); #1;
        check_val("irq_squash", 32'(squash), 32'd1);
        step(); irq = 1'b0; call = 1'b0; #1;
        check_val("irq_push", 32'(push), 32'd1);
        check_val("irq_push_data", 32'(push_data), 32'h020);
        check_val("irq_redirect", 32'(redirect), 32'd1);
        check_val("irq_redirect_pc", 32'(redirect_pc), 32'h3F0);
        check_val("irq_ie", 32'(ie), 32'd0);
        check_val("irq_in_isr", 32'(in_isr), 32'd1);
        check_val("irq_depth", 32'(depth), 32'd8);

        // reti returns to the interrupted PC and re-enables interrupts
        reti = 1'b1; step(); reti = 1'b0; pop_data = 10'h020; #1;
        check_val("reti_pop", 32'(pop), 32'd1);
        step(); pop_data = 10'h000; #1;
        check_val("reti_redirect", 32'(redirect), 32'd1);
        check_val("reti_redirect_pc", 32'(redirect_pc), 32'h020);
        check_val("reti_ie_n2", 32'(ie), 32'd0);
        step();
        check_val("reti_ie", 32'(ie), 32'd1);
        check_val("reti_in_isr", 32'(in_isr), 32'd0);
        check_val("reti_depth", 32'(depth), 32'd7);

        // irq ignored with ie cleared; di wins over ei
        di = 1'b1; ei = 1'b1; step(); di = 1'b0; ei = 1'b0; #1;
        check_val("di_clear", 32'(ie), 32'd0);
        irq = 1'b1; #1;
        check_val("irq_ie0_squash", 32'(squash), 32'd0);
        step(); irq = 1'b0; #1;
        check_val("irq_ie0_push", 32'(push), 32'd0);

        // reset dropped in the pop cycle of a ret
        ret = 1'b1; step(); ret = 1'b0; #1;
        check_val("mid_pop", 32'(pop), 32'd1);
        reset = 1'b0; #1;
        check_val("mid_rst_pop", 32'(pop), 32'd0);
        check_val("mid_rst_stall", 32'(stall), 32'd0);
        check_val("mid_rst_redirect", 32'(redirect), 32'd0);
        check_val("mid_rst_depth", 32'(depth), 32'd0);
        check_val("mid_rst_errs", {30'd0, ovf_err, unf_err}, 32'd0);
        step(); reset = 1'b1; step();
        check_val("post_rst_stall", 32'(stall), 32'd0);
        check_val("post_rst_redirect", 32'(redirect), 32'd0);
        call = 1'b1; pc_next = 10'h0AA; step(); call = 1'b0; #1;
        check_val("post_rst_push", 32'(push), 32'd1);
        check_val("post_rst_depth", 32'(depth), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/callret_ctrl.md
Name: callret_ctrl

Overview:
Initiator side of the return-address stack interface. Decodes call/return/interrupt events from the single-cycle CPU control path. Drives one-cycle push/pop strobes toward the LIFO return stack and tracks stack depth. Redirects the PC on return, and handles interrupt entry/exit with an interrupt-enable flag and sticky overflow/underflow error flags.

Parameters:
AW, 10, PC/return-address width (matches the PC bus)
DEPTH, 8, capacity of the attached return stack in entries
IRQ_VEC, 10'h3F0, PC loaded on interrupt entry

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
call  input  1  decoded call instruction this cycle
ret  input  1  decoded return instruction this cycle
reti  input  1  decoded return-from-interrupt this cycle
ei  input  1  set interrupt enable
di  input  1  clear interrupt enable
irq  input  1  level interrupt request
pc_cur  input  AW  PC of current instruction
pc_next  input  AW  PC+1 of current instruction
pop_data  input  AW  stack read data, valid in the cycle pop is high
push  output  1  one-cycle push strobe to stack
push_data  output  AW  address to push, valid with push
pop  output  1  one-cycle pop strobe to stack
stall  output  1  hold PC (combinational)
squash  output  1  current instruction preempted by irq (combinational)
redirect  output  1  load redirect_pc into PC
redirect_pc  output  AW  new PC, valid with redirect
ie  output  1  interrupt enable
in_isr  output  1  servicing interrupt
depth  output  $clog2(DEPTH+1)  entries currently on stack
ovf_err  output  1  sticky: push attempted when full
unf_err  output  1  sticky: pop attempted when empty

Behaviour:
- Reset (reset=0, async): state IDLE. depth=0, ie=0, in_isr=0. push/pop/redirect=0, push_data=redirect_pc=0, errors=0.
- States: IDLE, POP (pop strobe cycle), RDIR (redirect cycle). All strobes are registered except stall/squash.
- Accept priority in IDLE, cycle N:
  1. irq: irq & ie & depth<DEPTH
  2. ret/reti (ret and reti are mutually exclusive; reti is treated identically to ret except as noted)
  3. call
- irq accept:
  - squash=1 in N.
  - N+1: push=1, push_data=pc_cur, redirect=1, redirect_pc=IRQ_VEC.
  - depth+1, ie<=0, in_isr<=1.
  - call/ret/ei/di in N are ignored.
- ret/reti accept with depth>0:
  - stall=1 in N; state->POP.
  - N+1: pop=1, stall=1, depth-1. pop_data is captured at end of N+1; state->RDIR.
  - N+2: redirect=1, redirect_pc=captured data, stall=0; state->IDLE.
  - reti only: ie<=1, in_isr<=0 at end of N+2.
- ret/reti with depth=0: no pop, no stall, no state change; unf_err<=1.
- call accept with depth<DEPTH: N+1 push=1, push_data=pc_next(N), depth+1, no stall.
- call with depth=DEPTH: no push; ovf_err<=1.
- call and ret both high in the same cycle: ret wins, call is dropped (no flag).
- irq with ie=1 while depth=DEPTH: not accepted; it stays pending (level) until depth<DEPTH.
- In POP/RDIR: call/ret/reti/irq are ignored. The CPU is stalled in POP, so inputs there are don't-care.
- ei/di are applied in IDLE only, when no irq is accepted. di wins if both are high.
- depth never wraps: saturates at 0 and DEPTH by the guards above.
- Error flags clear only on reset.
- Reset mid-sequence (POP or RDIR): all outputs return to reset values immediately. No strobe completes.

Test Plan:
- Reset then call with pc_next=10'h005 -> next cycle push=1, push_data=10'h005, depth=1, stall=0 throughout.
- Preload depth=1 (data 10'h005), ret in N -> stall high N and N+1; pop=1 in N+1; redirect=1 in N+2 with redirect_pc=10'h005; depth=0.
- ret at depth=0 -> unf_err=1, pop never asserted, stall=0. 9 calls at DEPTH=8 -> 8 pushes, depth=8, ovf_err=1.
- ei, then irq=1 with call in the same cycle, pc_cur=10'h020 -> squash=1; next cycle push_data=10'h020, redirect_pc=10'h3F0, ie=0, in_isr=1, depth+1. Later reti -> redirect_pc=10'h020, ie=1, in_isr=0.
- irq=1 with ie=0, and irq=1 with ie=1 at depth=8 -> no accept, no push. After a ret completes (depth=7) the irq is accepted on the next IDLE cycle.
- Drop reset to 0 in cycle N+1 of a ret -> pop, stall, redirect all 0 asynchronously; depth=0, state IDLE after release.
